// File: rtl/rx_word_assembler_if.sv
// ---------------------------------------------------------------------------
// rx_word_assembler_if
// Bundles the decoder-side symbol stream, the readout side of the word FIFO
// and the status counters of rx_word_assembler.
//   slave  : the assembler (consumes symbols and READ, drives word/status)
//   master : the decoder/readout side that drives symbols and READ
// Signals:
//   ENABLE, CLR_CNT, DEC_VALID, DEC_K, DEC_DATA[7:0], DEC_ERR, READ   -> slave
//   DATA, TAG, EMPTY, FULL, SIZE, DECODER_ERR_CNT, TRUNC_CNT, LOST_CNT <- slave
// ---------------------------------------------------------------------------
interface rx_word_assembler_if #(
    parameter int BYTES_PER_WORD = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_WIDTH      = 8
);
    logic                            ENABLE;
    logic                            CLR_CNT;
    logic                            DEC_VALID;
    logic                            DEC_K;
    logic [7:0]                      DEC_DATA;
    logic                            DEC_ERR;
    logic                            READ;
    logic [BYTES_PER_WORD*8-1:0]     DATA;
    logic                            TAG;
    logic                            EMPTY;
    logic                            FULL;
    logic [$clog2(FIFO_DEPTH):0]     SIZE;
    logic [CNT_WIDTH-1:0]            DECODER_ERR_CNT;
    logic [CNT_WIDTH-1:0]            TRUNC_CNT;
    logic [CNT_WIDTH-1:0]            LOST_CNT;

    modport master (
        output ENABLE, CLR_CNT, DEC_VALID, DEC_K, DEC_DATA, DEC_ERR, READ,
        input  DATA, TAG, EMPTY, FULL, SIZE, DECODER_ERR_CNT, TRUNC_CNT, LOST_CNT
    );

    modport slave (
        input  ENABLE, CLR_CNT, DEC_VALID, DEC_K, DEC_DATA, DEC_ERR, READ,
        output DATA, TAG, EMPTY, FULL, SIZE, DECODER_ERR_CNT, TRUNC_CNT, LOST_CNT
    );
endinterface

// File: rtl/rx_word_assembler.sv
// ---------------------------------------------------------------------------
// rx_word_assembler
// Packs BYTES_PER_WORD decoded 8b10b data bytes (first byte in the MSBs) into
// words and buffers them in a FIFO_DEPTH-entry show-ahead FIFO. K symbols and
// decoder errors resynchronise the assembler; partial words discarded by them
// are counted in TRUNC_CNT, errors in DECODER_ERR_CNT and words dropped on a
// full FIFO in LOST_CNT. All counters saturate.
// Ports:
//   WCLK     word clock (rising edge)
//   RESET_N  asynchronous active-low reset
//   bus      rx_word_assembler_if.slave (symbol input, FIFO readout, counters)
// Optional feature: define RX_KWORD_RECORD_EN to store error-free K symbols
// equal to KWORD_CODE as tagged words (TAG = 1). Without it TAG is tied low.
// ---------------------------------------------------------------------------
module rx_word_assembler #(
    parameter int         BYTES_PER_WORD = 3,
    parameter int         FIFO_DEPTH     = 8,
    parameter int         CNT_WIDTH      = 8,
    parameter logic [7:0] KWORD_CODE     = 8'hFC
) (
    input logic               WCLK,
    input logic               RESET_N,
    rx_word_assembler_if.slave bus
);
    localparam int W      = BYTES_PER_WORD * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BSEL_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
`ifdef RX_KWORD_RECORD_EN
    localparam bit KW_EN = 1'b1;
`else
    localparam bit KW_EN = 1'b0;
`endif

    typedef enum logic {IDLE, COLLECT} state_t;

    // Saturating increment with clear taking priority.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(
        input logic [CNT_WIDTH-1:0] v, input logic clr, input logic inc);
        if (clr)
            return '0;
        else if (inc && !(&v))
            return v + CNT_WIDTH'(1);
        else
            return v;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [BSEL_W-1:0]   r_bsel, w_bsel_nxt;
    logic [W-1:0]        r_asm;
    logic [W-1:0]        w_next_asm;
    logic                r_wr_stb;
    logic [W-1:0]        r_wr_data;
    logic                w_accept, w_store, w_complete, w_trunc, w_kword;

    logic [W-1:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]      r_size;
    logic                w_full, w_empty, w_pop, w_push, w_lost;
    logic [CNT_WIDTH-1:0] r_err_cnt, r_trunc_cnt, r_lost_cnt;

    assign w_accept   = bus.DEC_VALID & bus.ENABLE;
    assign w_next_asm = (r_asm << 8) | W'(bus.DEC_DATA);

    // Next-state / decode
    always_comb begin
        w_state_nxt = r_state;
        w_bsel_nxt  = r_bsel;
        w_store     = 1'b0;
        w_complete  = 1'b0;
        w_trunc     = 1'b0;
        w_kword     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept && !bus.DEC_ERR && !bus.DEC_K) begin
                    w_store = 1'b1;
                    if (BYTES_PER_WORD == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = COLLECT;
                        w_bsel_nxt  = BSEL_W'(1);
                    end
                end else if (w_accept && !bus.DEC_ERR && bus.DEC_K) begin
                    w_kword = KW_EN && (bus.DEC_DATA == KWORD_CODE);
                end
            end
            COLLECT: begin
                if (!bus.ENABLE) begin
                    // Enable dropped mid-word: silent discard.
                    w_state_nxt = IDLE;
                    w_bsel_nxt  = '0;
                end else if (bus.DEC_VALID) begin
                    if (bus.DEC_ERR || bus.DEC_K) begin
                        w_trunc     = 1'b1;
                        w_kword     = KW_EN && !bus.DEC_ERR && bus.DEC_K &&
                                      (bus.DEC_DATA == KWORD_CODE);
                        w_state_nxt = IDLE;
                        w_bsel_nxt  = '0;
                    end else begin
                        w_store = 1'b1;
                        if (r_bsel == BSEL_W'(BYTES_PER_WORD - 1)) begin
                            w_complete  = 1'b1;
                            w_state_nxt = IDLE;
                            w_bsel_nxt  = '0;
                        end else begin
                            w_bsel_nxt = r_bsel + BSEL_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_bsel_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge WCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_bsel   <= '0;
            r_wr_stb <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bsel   <= w_bsel_nxt;
            r_wr_stb <= w_complete | w_kword;
        end
    end

    // Byte assembly and write staging: data only, no reset needed since every
    // written word is fully overwritten before its strobe.
    always_ff @(posedge WCLK) begin
        if (w_store)
            r_asm <= w_next_asm;
        if (w_kword)
            r_wr_data <= W'(KWORD_CODE);
        else if (w_complete)
            r_wr_data <= w_next_asm;
    end

    // Word FIFO
    assign w_full  = (r_size == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty = (r_size == '0);
    assign w_pop   = bus.READ & ~w_empty;
    // On a full FIFO a simultaneous pop frees the slot being written.
    assign w_push  = r_wr_stb & (~w_full | w_pop);
    assign w_lost  = r_wr_stb & w_full & ~w_pop;

    always_ff @(posedge WCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_size      <= '0;
            r_err_cnt   <= '0;
            r_trunc_cnt <= '0;
            r_lost_cnt  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_size <= r_size + (PTR_W+1)'(1);
            else if (w_pop && !w_push)
                r_size <= r_size - (PTR_W+1)'(1);
            r_err_cnt   <= cnt_next(r_err_cnt, bus.CLR_CNT, w_accept & bus.DEC_ERR);
            r_trunc_cnt <= cnt_next(r_trunc_cnt, bus.CLR_CNT, w_trunc);
            r_lost_cnt  <= cnt_next(r_lost_cnt, bus.CLR_CNT, w_lost);
        end
    end

    always_ff @(posedge WCLK) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_wr_data;
    end

`ifdef RX_KWORD_RECORD_EN
    logic r_wr_tag;
    logic r_tag_mem [FIFO_DEPTH];

    always_ff @(posedge WCLK) begin
        if (w_kword || w_complete)
            r_wr_tag <= w_kword;
        if (w_push)
            r_tag_mem[r_wr_ptr] <= r_wr_tag;
    end

    assign bus.TAG = ~w_empty & r_tag_mem[r_rd_ptr];
`else
    assign bus.TAG = 1'b0;
`endif

    // Head word is forced to zero while empty so reset shows DATA = 0.
    assign bus.DATA            = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.EMPTY           = w_empty;
    assign bus.FULL            = w_full;
    assign bus.SIZE            = r_size;
    assign bus.DECODER_ERR_CNT = r_err_cnt;
    assign bus.TRUNC_CNT       = r_trunc_cnt;
    assign bus.LOST_CNT        = r_lost_cnt;

endmodule

// File: tb/tb_rx_word_assembler.sv
module tb_rx_word_assembler;
    localparam int BPW   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    rx_word_assembler_if #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    rx_word_assembler #(
        .BYTES_PER_WORD(BPW),
        .FIFO_DEPTH    (DEPTH),
        .CNT_WIDTH     (CW),
        .KWORD_CODE    (8'hFC)
    ) dut (
        .WCLK    (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one symbol at a negedge, returns at the next negedge.
    task automatic sym(input logic k, input logic [7:0] d, input logic e);
        bus.DEC_VALID = 1'b1;
        bus.DEC_K     = k;
        bus.DEC_DATA  = d;
        bus.DEC_ERR   = e;
        @(negedge clk);
        bus.DEC_VALID = 1'b0;
        bus.DEC_K     = 1'b0;
        bus.DEC_ERR   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.DEC_VALID = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        bus.READ = 1'b1;
        @(negedge clk);
        bus.READ = 1'b0;
    endtask

    task automatic clr_counters();
        bus.CLR_CNT = 1'b1;
        @(negedge clk);
        bus.CLR_CNT = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.EMPTY); end
        n_cmp++; if (bus.FULL !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", bus.FULL); end
        n_cmp++; if (bus.SIZE !== 3'd0) begin n_fail++; $display("FAIL rst_size: got %0d want 0", bus.SIZE); end
        n_cmp++; if (bus.DATA !== 24'h0) begin n_fail++; $display("FAIL rst_data: got %h want 000000", bus.DATA); end
        n_cmp++; if (bus.TAG !== 1'b0) begin n_fail++; $display("FAIL rst_tag: got %b want 0", bus.TAG); end
        n_cmp++; if ({bus.DECODER_ERR_CNT, bus.TRUNC_CNT, bus.LOST_CNT} !== 24'h0) begin n_fail++;
            $display("FAIL rst_cnts: got %h/%h/%h want 00/00/00", bus.DECODER_ERR_CNT, bus.TRUNC_CNT, bus.LOST_CNT); end
        rst_n = 1'b1;
        bus.ENABLE = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_word();
        sym(1'b0, 8'h11, 1'b0);
        sym(1'b0, 8'h22, 1'b0);
        sym(1'b0, 8'h33, 1'b0);
        // One edge after the last byte: only the write strobe is up.
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL basic_empty_early: got %b want 1", bus.EMPTY); end
        idle(1);
        n_cmp++; if (bus.EMPTY !== 1'b0) begin n_fail++; $display("FAIL basic_empty_late: got %b want 0", bus.EMPTY); end
        n_cmp++; if (bus.DATA !== 24'h112233) begin n_fail++; $display("FAIL basic_data: got %h want 112233", bus.DATA); end
        n_cmp++; if (bus.SIZE !== 3'd1) begin n_fail++; $display("FAIL basic_size: got %0d want 1", bus.SIZE); end
        n_cmp++; if (bus.TAG !== 1'b0) begin n_fail++; $display("FAIL basic_tag: got %b want 0", bus.TAG); end
        n_cmp++; if (bus.TRUNC_CNT !== 8'd0) begin n_fail++; $display("FAIL basic_trunc: got %0d want 0", bus.TRUNC_CNT); end
        pop();
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL basic_pop_empty: got %b want 1", bus.EMPTY); end
    endtask

    task automatic test_k_truncation();
        clr_counters();
        sym(1'b0, 8'hAA, 1'b0);
        sym(1'b0, 8'hBB, 1'b0);
        sym(1'b1, 8'hBC, 1'b0);
        idle(3);
        n_cmp++; if (bus.TRUNC_CNT !== 8'd1) begin n_fail++; $display("FAIL ktrunc_cnt: got %0d want 1", bus.TRUNC_CNT); end
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL ktrunc_empty: got %b want 1", bus.EMPTY); end
        sym(1'b0, 8'h01, 1'b0);
        sym(1'b0, 8'h02, 1'b0);
        sym(1'b0, 8'h03, 1'b0);
        idle(2);
        n_cmp++; if (bus.DATA !== 24'h010203) begin n_fail++; $display("FAIL ktrunc_data: got %h want 010203", bus.DATA); end
        pop();
    endtask

    task automatic test_err_truncation();
        clr_counters();
        sym(1'b0, 8'h55, 1'b0);
        sym(1'b0, 8'h66, 1'b1);
        idle(2);
        n_cmp++; if (bus.DECODER_ERR_CNT !== 8'd1) begin n_fail++; $display("FAIL err_deccnt: got %0d want 1", bus.DECODER_ERR_CNT); end
        n_cmp++; if (bus.TRUNC_CNT !== 8'd1) begin n_fail++; $display("FAIL err_trunc: got %0d want 1", bus.TRUNC_CNT); end
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL err_empty: got %b want 1", bus.EMPTY); end
        sym(1'b0, 8'h77, 1'b0);
        sym(1'b0, 8'h88, 1'b0);
        sym(1'b0, 8'h99, 1'b0);
        idle(2);
        n_cmp++; if (bus.DATA !== 24'h778899) begin n_fail++; $display("FAIL err_data: got %h want 778899", bus.DATA); end
        pop();
    endtask

    task automatic test_enable_drop();
        clr_counters();
        sym(1'b0, 8'h12, 1'b0);
        bus.ENABLE = 1'b0;
        idle(1);
        bus.ENABLE = 1'b1;
        sym(1'b0, 8'h34, 1'b0);
        sym(1'b0, 8'h56, 1'b0);
        sym(1'b0, 8'h78, 1'b0);
        idle(2);
        n_cmp++; if (bus.DATA !== 24'h345678) begin n_fail++; $display("FAIL endrop_data: got %h want 345678", bus.DATA); end
        n_cmp++; if (bus.TRUNC_CNT !== 8'd0) begin n_fail++; $display("FAIL endrop_trunc: got %0d want 0", bus.TRUNC_CNT); end
        pop();
    endtask

    task automatic test_fifo_full();
        logic [23:0] exp_q [4];
        clr_counters();
        for (int n = 1; n <= 5; n++) begin
            sym(1'b0, 8'hA0 + 8'(n), 1'b0);
            sym(1'b0, 8'hB0 + 8'(n), 1'b0);
            sym(1'b0, 8'hC0 + 8'(n), 1'b0);
        end
        idle(2);
        n_cmp++; if (bus.FULL !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", bus.FULL); end
        n_cmp++; if (bus.SIZE !== 3'd4) begin n_fail++; $display("FAIL full_size: got %0d want 4", bus.SIZE); end
        n_cmp++; if (bus.LOST_CNT !== 8'd1) begin n_fail++; $display("FAIL full_lost: got %0d want 1", bus.LOST_CNT); end
        n_cmp++; if (bus.DATA !== 24'hA1B1C1) begin n_fail++; $display("FAIL full_head: got %h want a1b1c1", bus.DATA); end
        // Sixth word with READ on its write-strobe cycle.
        sym(1'b0, 8'hA6, 1'b0);
        sym(1'b0, 8'hB6, 1'b0);
        sym(1'b0, 8'hC6, 1'b0);
        pop();
        n_cmp++; if (bus.LOST_CNT !== 8'd1) begin n_fail++; $display("FAIL rw_lost: got %0d want 1", bus.LOST_CNT); end
        n_cmp++; if (bus.SIZE !== 3'd4) begin n_fail++; $display("FAIL rw_size: got %0d want 4", bus.SIZE); end
        n_cmp++; if (bus.DATA !== 24'hA2B2C2) begin n_fail++; $display("FAIL rw_head: got %h want a2b2c2", bus.DATA); end
        exp_q[0] = 24'hA2B2C2;
        exp_q[1] = 24'hA3B3C3;
        exp_q[2] = 24'hA4B4C4;
        exp_q[3] = 24'hA6B6C6;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.DATA !== exp_q[i]) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", i, bus.DATA, exp_q[i]); end
            pop();
        end
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", bus.EMPTY); end
        pop();
        n_cmp++; if (bus.SIZE !== 3'd0) begin n_fail++; $display("FAIL underflow_size: got %0d want 0", bus.SIZE); end
    endtask

    task automatic test_counter_saturation();
        clr_counters();
        for (int i = 0; i < 300; i++)
            sym(1'b0, 8'h00, 1'b1);
        n_cmp++; if (bus.DECODER_ERR_CNT !== 8'hFF) begin n_fail++; $display("FAIL sat_deccnt: got %h want ff", bus.DECODER_ERR_CNT); end
        n_cmp++; if (bus.TRUNC_CNT !== 8'd0) begin n_fail++; $display("FAIL sat_trunc: got %0d want 0", bus.TRUNC_CNT); end
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL sat_empty: got %b want 1", bus.EMPTY); end
        bus.CLR_CNT = 1'b1;
        sym(1'b0, 8'h00, 1'b1);
        bus.CLR_CNT = 1'b0;
        n_cmp++; if (bus.DECODER_ERR_CNT !== 8'h00) begin n_fail++; $display("FAIL clr_prio: got %h want 00", bus.DECODER_ERR_CNT); end
    endtask

    task automatic test_kword();
        clr_counters();
        sym(1'b1, 8'hFC, 1'b0);
        idle(2);
`ifdef RX_KWORD_RECORD_EN
        n_cmp++; if (bus.EMPTY !== 1'b0) begin n_fail++; $display("FAIL kword_empty: got %b want 0", bus.EMPTY); end
        n_cmp++; if (bus.TAG !== 1'b1) begin n_fail++; $display("FAIL kword_tag: got %b want 1", bus.TAG); end
        n_cmp++; if (bus.DATA !== 24'h0000FC) begin n_fail++; $display("FAIL kword_data: got %h want 0000fc", bus.DATA); end
        pop();
`else
        n_cmp++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL kword_empty: got %b want 1", bus.EMPTY); end
        n_cmp++; if (bus.TAG !== 1'b0) begin n_fail++; $display("FAIL kword_tag: got %b want 0", bus.TAG); end
`endif
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.ENABLE    = 1'b0;
        bus.CLR_CNT   = 1'b0;
        bus.DEC_VALID = 1'b0;
        bus.DEC_K     = 1'b0;
        bus.DEC_DATA  = 8'h00;
        bus.DEC_ERR   = 1'b0;
        bus.READ      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_word();
        test_k_truncation();
        test_err_truncation();
        test_enable_drop();
        test_fifo_full();
        test_counter_saturation();
        test_kword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Parametrised successor to the fixed 3-byte FE-I4 word builder.
- Takes a stream of already-decoded 8b10b symbols (data/K flag plus decoder error) in a single clock domain.
- Packs BYTES_PER_WORD data bytes into one word, MSB-first, and buffers the words in an internal FIFO of configurable depth.
- New compared with the fixed builder:
  - K-symbol and decoder-error resynchronisation, with separate saturating counters.
  - Truncated-word accounting.
  - Simultaneous read/write on a full FIFO.
- Sits between the 8b10b decoder and the bus-side readout FIFO.

Parameters:
- BYTES_PER_WORD, 3, data bytes per assembled word (1..8).
- FIFO_DEPTH, 8, word FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8, width of each saturating error counter.
- KWORD_CODE, 8'hFC, K symbol value recorded when RX_KWORD_RECORD_EN is defined (K28.7).

Ports:
- WCLK  in  1  word clock; all logic is on its rising edge.
- RESET_N  in  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
- ENABLE  in  1  accept symbols while high.
- CLR_CNT  in  1  synchronous clear of all three counters.
- DEC_VALID  in  1  qualifies DEC_K, DEC_DATA and DEC_ERR for one cycle.
- DEC_K  in  1  symbol is a K character.
- DEC_DATA  in  8  decoded byte.
- DEC_ERR  in  1  code or disparity error on this symbol.
- READ  in  1  pop the head word; ignored while EMPTY.
- DATA  out  BYTES_PER_WORD*8  head word (show-ahead); first received byte sits in the MSBs.
- TAG  out  1  head word is a recorded K word.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- SIZE  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- DECODER_ERR_CNT  out  CNT_WIDTH  counts DEC_VALID&DEC_ERR while ENABLE is high.
- TRUNC_CNT  out  CNT_WIDTH  counts partial words discarded.
- LOST_CNT  out  CNT_WIDTH  counts complete words dropped because the FIFO was full.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All counters = 0, SIZE = 0, EMPTY = 1, FULL = 0, DATA = 0, TAG = 0.
  - Byte index = 0, state = IDLE, write strobe = 0.
  - Assertion mid-word or mid-write discards everything.
- An accepted symbol is a cycle with DEC_VALID & ENABLE.
- State machine, with byte index bsel in 0..BYTES_PER_WORD-1:
  - IDLE (bsel = 0, no bytes held):
    - Accepted data symbol without error → store the byte at bsel 0. Go to COLLECT, or write the word immediately if BYTES_PER_WORD = 1.
    - K symbol or error → stay in IDLE; increment no truncation counter.
  - COLLECT:
    - Accepted data symbol without error → store the byte at bsel and increment bsel.
    - When the byte at bsel = BYTES_PER_WORD-1 is stored → pulse the write strobe next cycle and return to IDLE with bsel = 0.
    - Accepted K symbol → discard the partial word, TRUNC_CNT+1, go to IDLE.
    - Accepted symbol with DEC_ERR → discard the partial word, TRUNC_CNT+1, go to IDLE.
  - ENABLE falling in COLLECT → discard the partial word, go to IDLE, no count.
- DEC_ERR takes precedence over DEC_K.
- An error symbol is never stored.
- DECODER_ERR_CNT increments on every accepted DEC_ERR, independent of state.
- Latency:
  - Write strobe is high in the cycle after the edge that sampled the last byte.
  - EMPTY falls, and DATA/SIZE update, on the following edge: two edges after the last byte.
- FIFO rules:
  - Write and no READ with FULL = 1 → word dropped, LOST_CNT+1, contents unchanged.
  - Write and READ with FULL = 1 → pop and push in the same cycle; SIZE unchanged; no loss.
  - READ with EMPTY = 1 → no effect; SIZE never underflows.
  - Write and READ while not empty and not full → SIZE unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FULL = (SIZE == FIFO_DEPTH); EMPTY = (SIZE == 0).
- Counters:
  - Saturate at all-ones; no wrap.
  - CLR_CNT has priority over an increment in the same cycle.
- DEC_VALID low → all state held.

Optional Feature:
- Macro: RX_KWORD_RECORD_EN.
- Defined:
  - An accepted, error-free K symbol equal to KWORD_CODE is written to the FIFO as a word with TAG = 1 and DATA = {all upper bytes 8'h00, KWORD_CODE}.
  - Write timing and full/loss rules are identical to data words.
  - If it arrives in COLLECT, the partial word is still discarded and counted in TRUNC_CNT before the K word is written.
- Undefined:
  - No K word is ever stored.
  - TAG is tied to 0 and the tag storage is removed.

Test Plan:
- Defaults; data symbols 0x11, 0x22, 0x33 on consecutive cycles → DATA = 24'h112233 with EMPTY low exactly two edges after 0x33; TRUNC_CNT = 0.
- Send 0xAA, 0xBB, then K 0xBC → TRUNC_CNT = 1, FIFO stays empty; then 0x01, 0x02, 0x03 → DATA = 24'h010203.
- Send 0x55, then 0x66 with DEC_ERR → DECODER_ERR_CNT = 1, TRUNC_CNT = 1; then 0x77, 0x88, 0x99 → DATA = 24'h778899.
- FIFO_DEPTH = 4, READ held low, 5 complete words sent → FULL = 1, SIZE = 4, LOST_CNT = 1; a 6th word with READ pulsed on its write cycle → LOST_CNT stays 1, SIZE = 4, head = word 2.
- Drive 300 DEC_ERR symbols → DECODER_ERR_CNT = 8'hFF; CLR_CNT pulsed together with an error → counter = 0.
- RX_KWORD_RECORD_EN defined, send K 0xFC → TAG = 1, DATA = 24'h0000FC; without the macro, the same stimulus leaves EMPTY = 1.
